// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub, one STAGE_W-bit carry-ripple slice per stage; latency WIDTH/STAGE_W cycles.
// Backpressure: the whole pipe freezes while a result waits on out_ready, and in_ready drops for those cycles.
module pipelined_addsub #(
   parameter int WIDTH   = 16,
   parameter int STAGE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / STAGE_W;

   logic stall;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operands shrink by one slice per stage; the result grows by one slice.
      localparam int IN_W  = WIDTH - k * STAGE_W;
      localparam int REM_W = IN_W - STAGE_W;
      localparam int SUM_W = (k + 1) * STAGE_W;

      logic [IN_W-1:0]    a_in;
      logic [IN_W-1:0]    b_in;
      logic               v_in;
      logic               c_in;
      logic [STAGE_W:0]   slice;
      logic [SUM_W-1:0]   s_new;
      logic               vld_q;
      logic               c_q;
      logic [SUM_W-1:0]   s_q;

      if (k == 0) begin : g_head
         assign a_in  = a;
         assign b_in  = sub ? ~b : b;
         assign c_in  = sub | cin;
         assign v_in  = in_valid;
         assign s_new = slice[STAGE_W-1:0];
      end else begin : g_body
         assign a_in  = g_stage[k-1].g_opnd.a_q;
         assign b_in  = g_stage[k-1].g_opnd.b_q;
         assign c_in  = g_stage[k-1].c_q;
         assign v_in  = g_stage[k-1].vld_q;
         assign s_new = {slice[STAGE_W-1:0], g_stage[k-1].s_q};
      end

      assign slice = {1'b0, a_in[STAGE_W-1:0]} + {1'b0, b_in[STAGE_W-1:0]}
                   + {{STAGE_W{1'b0}}, c_in};

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            c_q   <= 1'b0;
            s_q   <= '0;
         end else if (!stall) begin
            vld_q <= v_in;
            c_q   <= slice[STAGE_W];
            s_q   <= s_new;
         end
      end

      if (REM_W > 0) begin : g_opnd
         logic [REM_W-1:0] a_q;
         logic [REM_W-1:0] b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_in[IN_W-1:STAGE_W];
               b_q <= b_in[IN_W-1:STAGE_W];
            end
         end
      end else begin : g_tail
         logic ovf_q;
         logic zero_q;

         // Carry into the MSB is recovered as a^b^s at that bit.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (!stall) begin
               ovf_q  <= a_in[STAGE_W-1] ^ b_in[STAGE_W-1] ^ slice[STAGE_W-1] ^ slice[STAGE_W];
               zero_q <= (s_new == '0);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].vld_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
   assign zero      = g_stage[STAGES-1].g_tail.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub across (8,8), (16,4) and (32,8) instances.
module tb_pipelined_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic [2:0]  in_valid_v;
   logic [31:0] a_v, b_v;
   logic        cin_v, sub_v;
   logic        out_ready;
   logic        ready_force = 1'b1;
   logic        rand_ready  = 1'b0;
   int          cfg;

   logic [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v, zero_v;
   logic [7:0]  sum8;
   logic [15:0] sum16;
   logic [31:0] sum32;

   assign in_valid_v[0] = in_valid && (cfg == 0);
   assign in_valid_v[1] = in_valid && (cfg == 1);
   assign in_valid_v[2] = in_valid && (cfg == 2);

   pipelined_addsub #(.WIDTH(8), .STAGE_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin_v), .sub(sub_v),
      .out_valid(out_valid_v[0]), .out_ready(out_ready), .sum(sum8),
      .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

   pipelined_addsub #(.WIDTH(16), .STAGE_W(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a_v[15:0]), .b(b_v[15:0]), .cin(cin_v), .sub(sub_v),
      .out_valid(out_valid_v[1]), .out_ready(out_ready), .sum(sum16),
      .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

   pipelined_addsub #(.WIDTH(32), .STAGE_W(8)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a_v), .b(b_v), .cin(cin_v), .sub(sub_v),
      .out_valid(out_valid_v[2]), .out_ready(out_ready), .sum(sum32),
      .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

   logic [31:0] cur_sum;
   logic        cur_in_ready, cur_out_valid, cur_cout, cur_ovf, cur_zero;

   always_comb begin
      case (cfg)
         0:       cur_sum = {24'd0, sum8};
         1:       cur_sum = {16'd0, sum16};
         default: cur_sum = sum32;
      endcase
      cur_in_ready  = in_ready_v[cfg[1:0]];
      cur_out_valid = out_valid_v[cfg[1:0]];
      cur_cout      = cout_v[cfg[1:0]];
      cur_ovf       = ovf_v[cfg[1:0]];
      cur_zero      = zero_v[cfg[1:0]];
   end

   function automatic int wid(input int c);
      case (c)
         0:       return 8;
         1:       return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int stages(input int c);
      case (c)
         0:       return 1;
         1:       return 4;
         default: return 4;
      endcase
   endfunction

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cfg %0d, cycle %0d)", tag, got, exp, cfg, cyc);
   endtask

   // Reference: sign rule on the effective addend, independent of any carry chain.
   function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic icin, input logic isub, input int w);
      logic [31:0] mask, aa, bb;
      logic [32:0] full;
      exp_t        e;
      mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      aa     = ia & mask;
      bb     = (isub ? ~ib : ib) & mask;
      full   = {1'b0, aa} + {1'b0, bb} + {32'd0, (isub | icin)};
      e.sum  = full[31:0] & mask;
      e.cout = full[w];
      e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
      e.zero = (e.sum == 32'd0);
      e.acc  = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (cur_out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", {31'd0, cur_out_valid}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sum",  cur_sum,  mon_e.sum);
            chk("cout", {31'd0, cur_cout}, {31'd0, mon_e.cout});
            chk("ovf",  {31'd0, cur_ovf},  {31'd0, mon_e.ovf});
            chk("zero", {31'd0, cur_zero}, {31'd0, mon_e.zero});
            if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'(stages(cfg)));
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                        input logic isub, input bit lat, input bit push);
      exp_t e;
      int   budget;
      a_v = ia; b_v = ib; cin_v = icin; sub_v = isub; in_valid = 1'b1;
      budget = 0;
      forever begin
         @(negedge clk);
         if (cur_in_ready) break;
         budget++;
         if (budget > 200) begin
            chk("accept_timeout", 32'(budget), 32'd0);
            break;
         end
      end
      if (push && budget <= 200) begin
         e     = model(ia, ib, icin, isub, wid(cfg));
         e.acc = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget = 0;
      while (sb.size() != 0 && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
      step();
   endtask

   task automatic stall_test();
      fork
         begin
            for (int i = 0; i < 6; i++) issue($urandom, $urandom, 1'b0, 1'(i % 2), 1'b0, 1'b1);
         end
         begin
            logic [31:0] held_sum;
            logic [2:0]  held_flags;
            int          t;
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!cur_out_valid && t < 50);
            chk("stall_first_valid", {31'd0, cur_out_valid}, 32'd1);
            step();
            ready_force = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("stall_in_ready", {31'd0, cur_in_ready}, 32'd0);
               chk("stall_out_valid", {31'd0, cur_out_valid}, 32'd1);
               if (k == 0) begin
                  held_sum   = cur_sum;
                  held_flags = {cur_cout, cur_ovf, cur_zero};
               end else begin
                  chk("stall_hold_sum", cur_sum, held_sum);
                  chk("stall_hold_flags", {29'd0, cur_cout, cur_ovf, cur_zero}, {29'd0, held_flags});
               end
            end
            step();
            ready_force = 1'b1;
            t = 0;
            forever begin
               @(negedge clk);
               if (sb.size() == 0 && !in_valid) break;
               chk("no_gap", {31'd0, cur_out_valid}, 32'd1);
               t++;
               if (t > 20) break;
            end
         end
      join
      drain("drain_stall");
   endtask

   task automatic reset_test();
      issue(32'h1111, 32'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(32'h3333, 32'h4444, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("flight_rst_valid", {31'd0, cur_out_valid}, 32'd0);
         if (k == 0) begin
            chk("flight_rst_sum", cur_sum, 32'd0);
            chk("flight_rst_flags", {29'd0, cur_cout, cur_ovf, cur_zero}, 32'd0);
            chk("flight_rst_in_ready", {31'd0, cur_in_ready}, 32'd1);
         end
      end
      step();
      issue(32'h00F0, 32'h000F, 1'b1, 1'b0, 1'b1, 1'b1);
      drain("drain_after_rst");
   endtask

   task automatic run_cfg(input int c);
      logic [31:0] mask, maxpos;
      cfg         = c;
      in_valid    = 1'b0;
      ready_force = 1'b1;
      rand_ready  = 1'b0;
      rst         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, cur_out_valid}, 32'd0);
      chk("rst_sum", cur_sum, 32'd0);
      chk("rst_flags", {29'd0, cur_cout, cur_ovf, cur_zero}, 32'd0);
      chk("rst_in_ready", {31'd0, cur_in_ready}, 32'd1);
      step();

      mask   = (wid(c) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(c)) - 32'd1);
      maxpos = mask >> 1;
      issue(mask,         32'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      issue(maxpos,       32'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      issue(32'h1234,     32'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      issue(32'd5,        32'd7, 1'b1, 1'b1, 1'b1, 1'b1);
      issue(maxpos + 1,   32'd1, 1'b0, 1'b1, 1'b1, 1'b1);
      issue(32'd0,        32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      drain("drain_directed");

      if (c == 1) begin
         stall_test();
         reset_test();
      end

      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 4) == 0) step();
         issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
      rand_ready = 1'b0;
      drain("drain_random");
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0;
      a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0;
      cfg = 0;
      for (int c = 0; c < 3; c++) run_cfg(c);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1, "simulation time limit");
   end

endmodule
